// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter for two valid/ready producers sharing one registered output
// stream. Grants are capped at BURST beats; ties go to the requester not served last.
module mux2_rr_arbiter #(
  parameter int WIDTH = 8,
  parameter int BURST = 4,
  localparam int CntW = $clog2(BURST + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  input  logic             y_ready,
  output logic             sel,
  output logic             busy,
  output logic [1:0]       dbg_state_o,
  output logic [CntW-1:0]  dbg_beat_cnt_o
);

  // Handshake: a beat moves on any port in a cycle where its valid and ready are both 1.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [CntW-1:0]   cnt_inc;
  logic              last_q, last_d;
  logic              sel_q, sel_d;
  logic              y_valid_q;
  logic [WIDTH-1:0]  y_data_q;
  logic              stall, accept, cur_valid, other_valid;

  assign stall   = y_valid_q && !y_ready;
  assign a_ready = (state_q == SERVE_A) && !stall;
  assign b_ready = (state_q == SERVE_B) && !stall;
  assign accept  = (a_valid && a_ready) || (b_valid && b_ready);

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    last_d      = last_q;
    cur_valid   = (state_q == SERVE_B) ? b_valid : a_valid;
    other_valid = (state_q == SERVE_B) ? a_valid : b_valid;
    cnt_inc     = beat_cnt_q + CntW'(accept);
    case (state_q)
      IDLE: begin
        // last_q = 1 means B was served last, so A wins a tie.
        if (a_valid && b_valid) state_d = last_q ? SERVE_A : SERVE_B;
        else if (a_valid)       state_d = SERVE_A;
        else if (b_valid)       state_d = SERVE_B;
      end
      SERVE_A, SERVE_B: begin
        if (!stall) begin
          beat_cnt_d = cnt_inc;
          if ((accept && (cnt_inc == CntW'(BURST))) || !cur_valid) begin
            last_d     = (state_q == SERVE_B);
            beat_cnt_d = '0;
            if (other_valid)    state_d = (state_q == SERVE_A) ? SERVE_B : SERVE_A;
            else if (cur_valid) state_d = state_q;
            else                state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_d = sel_q;
    if (state_d == SERVE_A)      sel_d = 1'b0;
    else if (state_d == SERVE_B) sel_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      last_q     <= 1'b1;
      sel_q      <= 1'b0;
      y_valid_q  <= 1'b0;
      y_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      last_q     <= last_d;
      sel_q      <= sel_d;
      if (accept) begin
        y_valid_q <= 1'b1;
        y_data_q  <= sel_q ? b_data : a_data;
      end else if (y_ready) begin
        y_valid_q <= 1'b0;
      end
    end
  end

  assign y_valid        = y_valid_q;
  assign y_data         = y_data_q;
  assign sel            = sel_q;
  assign busy           = (state_q != IDLE);
  assign dbg_state_o    = state_q;
  assign dbg_beat_cnt_o = beat_cnt_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter: a vector table walking grants, stalls and
// hand-offs, then sequences for continuous contention and reset mid-burst.
module tb_mux2_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_valid, b_valid, y_ready;
  logic [7:0] a_data, b_data;
  logic       a_ready, b_ready, y_valid, sel, busy;
  logic [7:0] y_data;
  logic [1:0] dbg_state;
  logic [2:0] dbg_cnt;

  int tests = 0;
  int failed = 0;

  mux2_rr_arbiter #(.WIDTH(8), .BURST(4)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .y_valid(y_valid), .y_data(y_data), .y_ready(y_ready),
    .sel(sel), .busy(busy),
    .dbg_state_o(dbg_state), .dbg_beat_cnt_o(dbg_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       av;
    logic [7:0] ad;
    logic       bv;
    logic [7:0] bd;
    logic       yr;
    logic       ar;
    logic       br;
    logic       yv;
    logic [7:0] yd;
    logic       sl;
    logic       bz;
    logic [1:0] st;
    logic [2:0] cnt;
  } vec_t;

  vec_t vq[$];
  logic [7:0] exp_q[$];

  task automatic add(input logic av, input logic [7:0] ad, input logic bv, input logic [7:0] bd,
                     input logic yr, input logic ar, input logic br, input logic yv,
                     input logic [7:0] yd, input logic sl, input logic bz,
                     input logic [1:0] st, input logic [2:0] cnt);
    vec_t v;
    v.av = av; v.ad = ad; v.bv = bv; v.bd = bd; v.yr = yr; v.ar = ar; v.br = br;
    v.yv = yv; v.yd = yd; v.sl = sl; v.bz = bz; v.st = st; v.cnt = cnt;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int beats;
    logic [7:0] a_sent, b_sent;
    logic acc_a, acc_b;

    rst = 1'b1; a_valid = 0; b_valid = 0; a_data = 0; b_data = 0; y_ready = 1'b1;
    tick(); tick();
    chk("rst_y_valid", y_valid, 0);
    chk("rst_y_data", y_data, 0);
    chk("rst_sel", sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_state", dbg_state, 0);
    chk("rst_cnt", dbg_cnt, 0);
    rst = 1'b0;

    //   av ad     bv bd     yr ar br yv yd     sl bz st cnt
    add(1, 8'h11, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 1, 1, 0);
    add(1, 8'h11, 0, 8'h00, 1, 1, 0, 1, 8'h11, 0, 1, 1, 1);
    add(1, 8'h22, 0, 8'h00, 1, 1, 0, 1, 8'h22, 0, 1, 1, 2);
    add(0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 8'h22, 0, 0, 0, 0);
    add(1, 8'h31, 1, 8'h41, 1, 0, 0, 0, 8'h22, 1, 1, 2, 0);
    add(1, 8'h31, 1, 8'h41, 1, 0, 1, 1, 8'h41, 1, 1, 2, 1);
    add(1, 8'h31, 1, 8'h5A, 1, 0, 1, 1, 8'h5A, 1, 1, 2, 2);
    add(1, 8'h31, 1, 8'h43, 0, 0, 0, 1, 8'h5A, 1, 1, 2, 2);
    add(1, 8'h31, 1, 8'h43, 0, 0, 0, 1, 8'h5A, 1, 1, 2, 2);
    add(1, 8'h31, 1, 8'h43, 0, 0, 0, 1, 8'h5A, 1, 1, 2, 2);
    add(1, 8'h31, 1, 8'h43, 1, 0, 1, 1, 8'h43, 1, 1, 2, 3);
    add(1, 8'h31, 1, 8'h44, 1, 0, 1, 1, 8'h44, 0, 1, 1, 0);
    add(1, 8'h31, 1, 8'h45, 1, 1, 0, 1, 8'h31, 0, 1, 1, 1);
    add(1, 8'h32, 1, 8'h45, 1, 1, 0, 1, 8'h32, 0, 1, 1, 2);
    add(0, 8'h00, 1, 8'h45, 1, 1, 0, 0, 8'h32, 1, 1, 2, 0);
    add(0, 8'h00, 1, 8'h45, 1, 0, 1, 1, 8'h45, 1, 1, 2, 1);
    add(0, 8'h00, 0, 8'h00, 1, 0, 1, 0, 8'h45, 1, 0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      a_valid = vq[i].av; a_data = vq[i].ad;
      b_valid = vq[i].bv; b_data = vq[i].bd;
      y_ready = vq[i].yr;
      #1;
      chk($sformatf("v%0d_a_ready", i), a_ready, vq[i].ar);
      chk($sformatf("v%0d_b_ready", i), b_ready, vq[i].br);
      tick();
      chk($sformatf("v%0d_y_valid", i), y_valid, vq[i].yv);
      chk($sformatf("v%0d_y_data", i), y_data, vq[i].yd);
      chk($sformatf("v%0d_sel", i), sel, vq[i].sl);
      chk($sformatf("v%0d_busy", i), busy, vq[i].bz);
      chk($sformatf("v%0d_state", i), dbg_state, vq[i].st);
      chk($sformatf("v%0d_cnt", i), dbg_cnt, vq[i].cnt);
    end

    // Continuous contention: A wins the first tie, then 4/4 alternation, no bubbles.
    rst = 1'b1; y_ready = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
    a_sent = 0; b_sent = 0; a_data = 8'hA0; b_data = 8'hB0;
    tick();
    rst = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) exp_q.push_back(8'hA0 + 8'(r * 4 + k));
      for (int k = 0; k < 4; k++) exp_q.push_back(8'hB0 + 8'(r * 4 + k));
    end
    beats = 0;
    for (int c = 0; c < 17; c++) begin
      #1;
      acc_a = a_valid && a_ready;
      acc_b = b_valid && b_ready;
      tick();
      if (y_valid) begin
        beats++;
        if (exp_q.size() == 0) chk("rr_extra_beat", y_data, 8'hFF);
        else chk($sformatf("rr_beat%0d", beats), y_data, exp_q.pop_front());
      end
      if (acc_a) a_sent++;
      if (acc_b) b_sent++;
      a_data = 8'hA0 + a_sent;
      b_data = 8'hB0 + b_sent;
    end
    chk("rr_beat_count", beats, 16);
    chk("rr_queue_left", exp_q.size(), 0);

    // Reset in the middle of an A burst drops the held beat.
    rst = 1'b1; a_valid = 0; b_valid = 0; y_ready = 1'b1;
    tick();
    rst = 1'b0; a_valid = 1'b1; a_data = 8'h77;
    tick(); tick(); tick();
    chk("mid_cnt", dbg_cnt, 2);
    chk("mid_y_valid", y_valid, 1);
    rst = 1'b1; b_valid = 1'b1;
    tick();
    chk("mrst_y_valid", y_valid, 0);
    chk("mrst_state", dbg_state, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_cnt", dbg_cnt, 0);
    #1;
    chk("mrst_a_ready", a_ready, 0);
    rst = 1'b0;
    tick();
    chk("mrst_tie_state", dbg_state, 1);
    chk("mrst_tie_sel", sel, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
